// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter.
// Runs the host request sequence (clock inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop) and then checks the device ACK. The lines are
// open-drain: this block only ever requests a pull-low, and the top level
// turns that into a tri-state pad shared with the receive path.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    // Line synchronizers; clk_prev_q is the third flop used for edge detection.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic clk_fe;

    state_t        state_q,   state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          parity_q,  parity_d;
    logic          clk_drv_q, clk_drv_d;
    logic          dat_drv_q, dat_drv_d;
    logic          timed;
    logic          timeout;

    // Bring the asynchronous PS/2 lines into the Clock domain.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_meta_q <= 1'b0;
            clk_sync_q <= 1'b0;
            clk_prev_q <= 1'b0;
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Cleared flops give prev = 0, so no false edge is seen right after reset.
    assign clk_fe = clk_prev_q & ~clk_sync_q;

    // State, counters, shift register and registered pull-low enables.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            clk_drv_q <= clk_drv_d;
            dat_drv_q <= dat_drv_d;
        end
    end

    // The frame timeout window covers RTS through WAIT_IDLE.
    always_comb begin
        timed   = (state_q == S_RTS)    || (state_q == S_DATA) ||
                  (state_q == S_PARITY) || (state_q == S_STOP) ||
                  (state_q == S_WAIT_IDLE);
        timeout = timed && (to_cnt_q == TO_LAST);
    end

    // Next-state logic. Drive enables are computed for the next state so the
    // outputs come straight from flops; data only moves after a detected fe.
    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        clk_drv_d = 1'b0;
        dat_drv_d = dat_drv_q;

        case (state_q)
            S_IDLE: begin
                dat_drv_d = 1'b0;
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = ~^tx_data;
                    state_d   = S_INHIBIT;
                    clk_drv_d = 1'b1;
                    dat_drv_d = (INH_LAST == '0);
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d   = S_RTS;
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b1;
                    to_cnt_d  = '0;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                    clk_drv_d = 1'b1;
                    dat_drv_d = ((inh_cnt_q + IW'(1)) == INH_LAST);
                end
            end
            S_RTS: begin
                if (clk_fe) begin
                    dat_drv_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_fe) begin
                    if (bit_cnt_q == 3'd7) begin
                        dat_drv_d = ~parity_q;
                        state_d   = S_PARITY;
                    end else begin
                        dat_drv_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (clk_fe) begin
                    dat_drv_d = 1'b0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                dat_drv_d = 1'b0;
                if (clk_fe) begin
                    state_d = dat_sync_q ? S_ERROR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                dat_drv_d = 1'b0;
                if (clk_sync_q && dat_sync_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dat_drv_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_ERROR: begin
                dat_drv_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                dat_drv_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Timeout overrides whatever the case above decided, including an fe
        // arriving in the same cycle.
        if (timed) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        if (timeout) begin
            state_d   = S_ERROR;
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            to_cnt_d  = to_cnt_q;
        end
    end

    // Status outputs decode the registered state.
    assign tx_ready          = (state_q == S_IDLE);
    assign busy              = (state_q != S_IDLE);
    assign tx_done           = (state_q == S_DONE);
    assign tx_error          = (state_q == S_ERROR);
    assign ps2_clk_drive_low = clk_drv_q;
    assign ps2_dat_drive_low = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural PS/2 device clocks frames out
// of the host over wired-AND lines and the sampled bits are compared with the
// frame computed from the byte.
module tb_ps2_host_transmitter;

    localparam int unsigned INH = 60;
    localparam int unsigned TMO = 4000;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       dev_clk;
    logic       dev_dat;
    logic       ps2_clk_line;
    logic       ps2_dat_line;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int accept_cnt = 0;

    assign ps2_clk_line = dev_clk & ~ps2_clk_drive_low;
    assign ps2_dat_line = dev_dat & ~ps2_dat_drive_low;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .PS2_CLK           (ps2_clk_line),
        .PS2_DAT           (ps2_dat_line),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (tx_done)             done_cnt   <= done_cnt + 1;
        if (tx_error)            err_cnt    <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt   <= both_cnt + 1;
        if (tx_valid && tx_ready && !Reset) accept_cnt <= accept_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bits seen on the line at device rising edges 1..10: data LSB first,
    // odd parity, then the released stop bit.
    function automatic logic [9:0] expected_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        check_eq("ready_wait", 32'(tx_ready), 32'd1);
    endtask

    // Device side of one frame; called at the negedge of the first inhibit cycle.
    task automatic dev_frame(input bit ack, input int half, output logic [9:0] bits);
        int   n;
        logic last_dat;
        bits = '1;
        n = 0;
        while (!ps2_clk_drive_low && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        last_dat = 1'b0;
        while (ps2_clk_drive_low && n < int'(INH) * 4) begin
            last_dat = ps2_dat_drive_low;
            n++;
            @(negedge Clock);
        end
        check_eq("inhibit_len", n, INH);
        check_eq("dat_low_end_inhibit", 32'(last_dat), 32'd1);
        check_eq("rts_start_bit", 32'(ps2_dat_line), 32'd0);
        repeat (5) @(negedge Clock);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_dat = ack ? 1'b0 : 1'b1;
            repeat (half) @(negedge Clock);
            dev_clk = 1'b0;
            repeat (half) @(negedge Clock);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_dat_line;
        end
        repeat (half) @(negedge Clock);
        dev_dat = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int half);
        logic [9:0] got;
        int d0, e0, n;
        wait_ready();
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge Clock);
        tx_valid = 1'b0;
        check_eq("ready_drop", 32'(tx_ready), 32'd0);
        dev_frame(ack, half, got);
        check_eq("frame_bits", 32'(got), 32'(expected_frame(d)));
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        check_eq("done_pulses", done_cnt - d0, ack ? 1 : 0);
        check_eq("error_pulses", err_cnt - e0, ack ? 0 : 1);
        check_eq("idle_after", 32'({tx_ready, busy, ps2_clk_drive_low, ps2_dat_drive_low}), 32'b1000);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got;
        int n, d0, e0, a0;

        Reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(negedge Clock);
        check_eq("reset_state",
                 32'({tx_ready, busy, ps2_clk_drive_low, ps2_dat_drive_low, tx_done, tx_error}),
                 32'b100000);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);

        // Directed frames.
        run_frame(8'hED, 1'b1, 20);
        run_frame(8'h07, 1'b1, 20);
        run_frame(8'h00, 1'b0, 20);

        // Device never clocks: error exactly TMO cycles after clock release.
        wait_ready();
        d0 = done_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge Clock);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_drive_low && n < int'(INH) * 4) begin
            @(negedge Clock);
            n++;
        end
        check_eq("timeout_rts_dat", 32'(ps2_dat_drive_low), 32'd1);
        n = 0;
        while (!tx_error && n < int'(TMO) * 2) begin
            @(negedge Clock);
            n++;
        end
        check_eq("timeout_cycles", n, TMO);
        check_eq("timeout_lines", 32'({ps2_clk_drive_low, ps2_dat_drive_low}), 32'd0);
        repeat (5) @(negedge Clock);
        check_eq("timeout_no_done", done_cnt - d0, 0);

        // Reset in the middle of the data bits.
        wait_ready();
        tx_data  = 8'h9A;
        tx_valid = 1'b1;
        @(negedge Clock);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_drive_low && n < int'(INH) * 4) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            repeat (15) @(negedge Clock);
            dev_clk = 1'b0;
            repeat (15) @(negedge Clock);
            dev_clk = 1'b1;
        end
        check_eq("bit4_on_line", 32'(ps2_dat_line), 32'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("mid_reset_state",
                 32'({tx_ready, busy, ps2_clk_drive_low, ps2_dat_drive_low, tx_done, tx_error}),
                 32'b100000);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        check_eq("mid_reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        run_frame(8'hF4, 1'b1, 20);

        // tx_valid held high: one frame per accept, re-accept only once idle.
        wait_ready();
        d0 = done_cnt;
        a0 = accept_cnt;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge Clock);
        check_eq("hold_ready_drop", 32'(tx_ready), 32'd0);
        dev_frame(1'b1, 15, got);
        check_eq("hold_bits1", 32'(got), 32'(expected_frame(8'hFF)));
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check_eq("hold_accepts_first", accept_cnt - a0, 1);
        n = 0;
        while (accept_cnt - a0 < 2 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        tx_valid = 1'b0;
        check_eq("hold_reaccept", accept_cnt - a0, 2);
        dev_frame(1'b1, 15, got);
        check_eq("hold_bits2", 32'(got), 32'(expected_frame(8'hFF)));
        n = 0;
        while (done_cnt - d0 < 2 && n < 500) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        check_eq("hold_done_total", done_cnt - d0, 2);
        check_eq("hold_accept_total", accept_cnt - a0, 2);

        // Randomized bytes, ACK behaviour and device clock rate.
        for (int k = 0; k < 12; k++) begin
            run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                      int'($urandom_range(8, 25)));
        end

        check_eq("done_error_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
